// File: rtl/mode_controller_n.sv
// mode_controller_n: menu/song/level/remap sequencer, engine output mux, tick base.
// Ports: buttons, note/len keys, engine buses in; eng_en/song/level/mod_sel/board out.
// Optional: `define CONFIRM_BEEP_EN adds a confirmation beep on buzzer.
module mode_controller_n #(
  parameter int          KEY_BITS  = 7,
  parameter int          NUM_MODES = 4,
  parameter logic [31:0] SONG_MASK = 32'b1110,
  parameter int          NUM_SONGS = 2,
  parameter int          SONG_BITS = 3,
  parameter int          LEVEL_MAX = 6,
  parameter int          TUBE_BITS = 8,
  parameter int          TICK_DIV  = 100000,
  parameter int          TIME_BITS = 16
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           submit,
  input  logic                           cancel,
  input  logic                           up,
  input  logic                           down,
  input  logic                           remap_clr,
  input  logic [KEY_BITS-1:0]            note_key,
  input  logic [KEY_BITS-1:0]            len_key,
  input  logic [NUM_MODES*KEY_BITS-1:0]  eng_led,
  input  logic [NUM_MODES-1:0]           eng_buzzer,
  input  logic [NUM_MODES*TUBE_BITS-1:0] eng_seg_en,
  input  logic [NUM_MODES*TUBE_BITS-1:0] eng_tube1,
  input  logic [NUM_MODES*TUBE_BITS-1:0] eng_tube2,
  output logic [NUM_MODES-1:0]           eng_en,
  output logic [SONG_BITS-1:0]           song,
  output logic [2:0]                     level,
  output logic [1:0]                     mod_sel,
  output logic [KEY_BITS-1:0]            mapped_key,
  output logic [TIME_BITS-1:0]           sys_time,
  output logic                           buzzer,
  output logic [KEY_BITS-1:0]            led,
  output logic [TUBE_BITS-1:0]           seg_en,
  output logic [TUBE_BITS-1:0]           tube1,
  output logic [TUBE_BITS-1:0]           tube2
);

  localparam int KIW = (KEY_BITS > 1) ? $clog2(KEY_BITS) : 1;
  localparam int MW  = (NUM_MODES > 1) ? $clog2(NUM_MODES) : 1;
  localparam int RW  = $clog2(KEY_BITS + 1);
  localparam int DW  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [2:0] LVL_RST = 3'(LEVEL_MAX / 2);

  typedef enum logic [1:0] {MENU, SEL, RUN, REMAP} state_t;

  state_t              state;
  logic [MW-1:0]       mode;
  logic [RW-1:0]       rcnt;
  logic [KEY_BITS-1:0] map_q [KEY_BITS];
  logic [DW-1:0]       div;
  logic [4:0]          s1, s2, s3;
  logic                c_p, clr_p, sub_p, up_p, dn_p;
  logic                vk;
  logic [KIW-1:0]      kidx;
  logic [1:0]          mod_d;
  logic                go_c, go_clr, go_sub, go_ud;
  logic                sub_mode, sub_rmp, sub_song, sub_map;
  logic                beep;
  logic                unused_ok;

  assign unused_ok = ^len_key[KEY_BITS-1:4];

  function automatic logic [KIW-1:0] oh_idx(input logic [KEY_BITS-1:0] v);
    oh_idx = '0;
    for (int i = 0; i < KEY_BITS; i++)
      if (v[i]) oh_idx = KIW'(i);
  endfunction

  // s3 is only the edge-detect history, so a rise acts two edges later
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= '0;
      s2 <= '0;
      s3 <= '0;
    end else begin
      s1 <= {cancel, remap_clr, submit, up, down};
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign {c_p, clr_p, sub_p, up_p, dn_p} = s2 & ~s3;

  assign vk   = $onehot(note_key);
  assign kidx = oh_idx(note_key);

  always_comb begin
    mod_d = 2'd0;
    if ($onehot(len_key[3:0]))
      unique case (1'b1)
        len_key[1]: mod_d = 2'd1;
        len_key[2]: mod_d = 2'd2;
        len_key[3]: mod_d = 2'd3;
        default:    mod_d = 2'd0;
      endcase
  end

  always_comb begin
    mapped_key = '0;
    for (int i = 0; i < KEY_BITS; i++)
      if (note_key[i]) mapped_key = mapped_key | map_q[i];
  end

  // a higher-priority pulse swallows lower ones even when it does nothing
  assign go_c     = c_p && state != MENU;
  assign go_clr   = !c_p && clr_p && state == REMAP;
  assign go_sub   = !c_p && !clr_p && sub_p && vk;
  assign go_ud    = !c_p && !clr_p && !sub_p && state == SEL
                    && (up_p ^ dn_p);
  assign sub_mode = go_sub && state == MENU
                    && int'(kidx) < NUM_MODES;
  assign sub_rmp  = go_sub && state == MENU
                    && int'(kidx) == NUM_MODES;
  assign sub_song = go_sub && state == SEL
                    && int'(kidx) < NUM_SONGS;
  assign sub_map  = go_sub && state == REMAP;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= MENU;
      mode    <= '0;
      rcnt    <= '0;
      eng_en  <= '0;
      song    <= '0;
      level   <= LVL_RST;
      mod_sel <= '0;
      for (int i = 0; i < KEY_BITS; i++)
        map_q[i] <= KEY_BITS'(1) << i;
    end else if (go_c) begin
      state  <= MENU;
      eng_en <= '0;
      song   <= '0;
      rcnt   <= '0;
    end else if (go_clr) begin
      state <= MENU;
      rcnt  <= '0;
      for (int i = 0; i < KEY_BITS; i++)
        map_q[i] <= KEY_BITS'(1) << i;
    end else begin
      if (sub_mode) begin
        mode <= MW'(kidx);
        if (SONG_MASK[kidx]) begin
          state <= SEL;
        end else begin
          state  <= RUN;
          eng_en <= NUM_MODES'(1) << kidx;
        end
      end
      if (sub_rmp) begin
        state <= REMAP;
        rcnt  <= '0;
      end
      if (sub_song) begin
        song    <= SONG_BITS'(int'(kidx) + 1);
        mod_sel <= mod_d;
        state   <= RUN;
        eng_en  <= NUM_MODES'(1) << mode;
      end
      if (sub_map) begin
        map_q[kidx] <= KEY_BITS'(1) << rcnt;
        if (int'(rcnt) == KEY_BITS - 1) begin
          state <= MENU;
          rcnt  <= '0;
        end else begin
          rcnt <= rcnt + RW'(1);
        end
      end
      if (go_ud) begin
        if (up_p && int'(level) < LEVEL_MAX)
          level <= level + 3'd1;
        if (dn_p && level != 3'd0)
          level <= level - 3'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div      <= '0;
      sys_time <= '0;
    end else if (int'(div) == TICK_DIV - 1) begin
      div      <= '0;
      sys_time <= sys_time + TIME_BITS'(1);
    end else begin
      div <= div + DW'(1);
    end
  end

`ifdef CONFIRM_BEEP_EN
  localparam int BEEP_LEN  = TICK_DIV * 2;
  localparam int BEEP_HALF = (TICK_DIV / 400 > 0) ? TICK_DIV / 400 : 1;
  localparam int BLW = $clog2(BEEP_LEN + 1);
  localparam int BHW = $clog2(BEEP_HALF + 1);

  logic [BLW-1:0] b_left;
  logic [BHW-1:0] b_ph;
  logic           b_sq;
  logic           b_start, b_stop;

  // anything that lands in RUN or cancels kills the beep
  assign b_stop  = go_c || state == RUN || sub_song
                   || (sub_mode && !SONG_MASK[kidx]);
  assign b_start = go_clr || sub_mode || sub_rmp || sub_map;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      b_left <= '0;
      b_ph   <= '0;
      b_sq   <= 1'b0;
    end else if (b_stop) begin
      b_left <= '0;
      b_ph   <= '0;
      b_sq   <= 1'b0;
    end else if (b_start) begin
      b_left <= BLW'(BEEP_LEN);
      b_ph   <= '0;
      b_sq   <= 1'b1;
    end else if (b_left != '0) begin
      b_left <= b_left - BLW'(1);
      if (int'(b_ph) == BEEP_HALF - 1) begin
        b_ph <= '0;
        b_sq <= ~b_sq;
      end else begin
        b_ph <= b_ph + BHW'(1);
      end
    end
  end

  assign beep = b_sq && b_left != '0;
`else
  assign beep = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led    <= '0;
      buzzer <= 1'b0;
      seg_en <= '0;
      tube1  <= '0;
      tube2  <= '0;
    end else begin
      led    <= '0;
      buzzer <= beep;
      seg_en <= '0;
      tube1  <= '0;
      tube2  <= '0;
      case (state)
        RUN: begin
          led    <= eng_led[mode*KEY_BITS +: KEY_BITS];
          buzzer <= eng_buzzer[mode];
          seg_en <= eng_seg_en[mode*TUBE_BITS +: TUBE_BITS];
          tube1  <= eng_tube1[mode*TUBE_BITS +: TUBE_BITS];
          tube2  <= eng_tube2[mode*TUBE_BITS +: TUBE_BITS];
        end
        SEL:     led <= KEY_BITS'(1) << level;
        REMAP:   led <= KEY_BITS'(1) << rcnt;
        default: led <= '0;
      endcase
    end
  end

endmodule

// File: doc/mode_controller_n.md
Name: mode_controller_n

Overview:
Parametrised top-level mode sequencer for the keyboard/buzzer instrument. It replaces a fixed menu FSM that had hard-coded mode and song counts.
- Selects one of NUM_MODES mode engines from a menu, runs song/difficulty selection for engines that need it, and gates engine enables.
- Muxes the engines' led/buzzer/tube outputs to the board.
- Owns the key-remap table; remap capture is a synchronous FSM.
- Generates the shared tick time base.

Parameters:
KEY_BITS, 7, note-key width; also remap table depth
NUM_MODES, 4, number of engines; 1..KEY_BITS-1
SONG_MASK, 4'b1110, bit i=1 means mode i needs song selection
NUM_SONGS, 2, selectable songs; 1..KEY_BITS
SONG_BITS, 3, song code width; code 0 = no song
LEVEL_MAX, 6, highest difficulty level; LEVEL_MAX < KEY_BITS
TUBE_BITS, 8, 7-seg bus width
TICK_DIV, 100000, clk cycles per tick
TIME_BITS, 16, tick counter width

Ports:
clk  in  1  system clock
rst_n  in  1  reset
submit  in  1  confirm button, level, async to clk
cancel  in  1  back button, level
up  in  1  increment button, level
down  in  1  decrement button, level
remap_clr  in  1  restore identity key map, level
note_key  in  KEY_BITS  physical note switches
len_key  in  KEY_BITS  length/mod switches
eng_led  in  NUM_MODES*KEY_BITS  engine leds, mode i at [i*KEY_BITS +: KEY_BITS]
eng_buzzer  in  NUM_MODES  engine buzzers
eng_seg_en/eng_tube1/eng_tube2  in  NUM_MODES*TUBE_BITS  engine display buses
eng_en  out  NUM_MODES  one-hot engine enable
song  out  SONG_BITS  selected song code
level  out  3  difficulty
mod_sel  out  2  play modifier
mapped_key  out  KEY_BITS  note_key through remap table, combinational
sys_time  out  TIME_BITS  tick count
buzzer  out  1  board buzzer
led  out  KEY_BITS  board leds
seg_en/tube1/tube2  out  TUBE_BITS  board display

Behaviour:
- Reset: rst_n, asynchronous, active-low; clock clk. All outputs 0 except level=LEVEL_MAX/2 rounded down. State=MENU. Remap table = identity (entry i = 1<<i). Tick counters = 0.
- Tick: div counts 0..TICK_DIV-1. When div wraps, sys_time increments, wrapping mod 2^TIME_BITS.
- Buttons: each button passes a 2-FF synchroniser plus a rising-edge detector. A rise sampled at edge k changes state at edge k+2. Held buttons give one pulse.
- Priority within a cycle: cancel > remap_clr > submit > up/down. If up and down pulse together, neither is applied.
- "Valid key" means note_key is exactly one-hot.
- MENU:
  - submit with note_key bit i < NUM_MODES: mode<=i. Go to SEL if SONG_MASK[i], else RUN.
  - submit with bit NUM_MODES: go to REMAP, rcnt<=0.
  - Any other key value: ignored.
- SEL:
  - up/down change level by 1, saturating at 0 and LEVEL_MAX.
  - submit with valid bit j < NUM_SONGS: song<=j+1. mod_sel<=index of len_key bits 0..3 if one-hot, else 0. Go to RUN.
  - Invalid submit: ignored.
- RUN: eng_en = 1<<mode; all other modes stay 0.
- REMAP:
  - submit with valid key bit p: table[p]<=1<<rcnt, rcnt++. Invalid key: ignored.
  - When rcnt reaches KEY_BITS, go to MENU on the same edge as the last write.
  - remap_clr: table<=identity, go to MENU.
- cancel in any non-MENU state: go to MENU; eng_en<=0, song<=0, rcnt<=0. Table and level are kept.
- mapped_key = OR over i of (note_key[i] ? table[i] : 0). Zero latency.
- Output register stage, 1-cycle latency:
  - RUN: led, buzzer, seg_en, tube1, tube2 = engine[mode] values.
  - SEL: led=1<<level.
  - REMAP: led=1<<rcnt.
  - MENU: led=0.
  - Outside RUN: buzzer=0, seg_en=0, tubes=0.
- Reset mid-operation: immediate return to the reset values above, including the remap table.

Optional Feature:
CONFIRM_BEEP_EN:
- Defined: each accepted submit or remap_clr outside RUN starts a beep on buzzer for BEEP_LEN=TICK_DIV*2 cycles. The beep is a square wave toggling every BEEP_HALF=TICK_DIV/400 cycles. Entering RUN or cancel truncates it.
- Undefined: buzzer is 0 outside RUN.

Test Plan:
- Reset -> state MENU, eng_en=0, song=0, level=3, led=0, mapped_key=note_key for note_key=7'b0000100.
- MENU submit note_key=0000001 -> eng_en=0001 2 cycles after the sync edge; buzzer follows eng_buzzer[0] 1 cycle later; cancel -> eng_en=0, led=0.
- MENU submit 0000010; SEL: up x5 -> level=6 (saturates); down+up in the same cycle -> level unchanged; submit note_key=0000010 with len_key=0000100 -> song=2, mod_sel=2, eng_en=0010.
- SEL submit with note_key=0000011 or 0100000 -> no state change.
- REMAP: 7 submits with keys 1<<(6-n) -> table reversed and MENU; then note_key=0000001 -> mapped_key=1000000; remap_clr in a new REMAP -> identity restored.
- TICK_DIV=4: sys_time increments every 4 clk; wraps from 2^TIME_BITS-1 to 0; cancel and submit in the same cycle in RUN -> MENU wins.
